vector_mem_sequencer: RTL and testbench

Sits directly upstream of the memory stage. It splits 256-bit vector loads and stores into the narrower transfers that the memory stage's data port accepts: 128-bit read beats and 64-bit write beats. Load beats are reassembled into a 256-bit result for writeback alongside VALU results. While a transfer is in flight, the block stalls the pipeline.

---
 rtl/vector_mem_sequencer.sv | 137 +++++++++++++
 tb/tb_vector_mem_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// Splits 256-bit vector loads/stores into 128-bit read beats and 64-bit write
// beats for the memory stage, reassembles load data and stalls the pipeline meanwhile.
module vector_mem_sequencer #(
  parameter int READ_LATENCY     = 1,
  parameter int LOAD_BEAT_BYTES  = 16,
  parameter int STORE_BEAT_BYTES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_load,
  input  logic         start_store,
  input  logic [31:0]  base_address,
  input  logic [255:0] store_data,
  input  logic [127:0] vector_output,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_vector_input,
  output logic         mem_write_enable,
  output logic [255:0] load_data,
  output logic         busy,
  output logic         done,
  output logic         stall
);

  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_DRAIN, ST_WRITE, DONE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [63:0]             wdat_q, wdat_d;
  logic                    we_q, we_d;
  logic [255:0]            ld_q, ld_d;
  logic [255:0]            sdat_q, sdat_d;
  logic [READ_LATENCY-1:0] tvld_q, ttag_q;
  logic                    issue_d, issue_tag_d;
  logic                    cap_vld, cap_tag;
  logic [31:0]             aligned;

  assign aligned = {base_address[31:4], 4'b0000};
  // The oldest tag stage lines up with the data returned for that beat's address.
  assign cap_vld = tvld_q[READ_LATENCY-1];
  assign cap_tag = ttag_q[READ_LATENCY-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    we_d        = 1'b0;
    ld_d        = ld_q;
    sdat_d      = sdat_q;
    issue_d     = 1'b0;
    issue_tag_d = 1'b0;
    if (cap_vld) begin
      if (cap_tag) ld_d[255:128] = vector_output;
      else         ld_d[127:0]   = vector_output;
    end
    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LD_ISSUE;
          cnt_d   = 2'd0;
          addr_d  = aligned;
          issue_d = 1'b1;
        end else if (start_store) begin
          state_d = ST_WRITE;
          cnt_d   = 2'd0;
          addr_d  = aligned;
          wdat_d  = store_data[63:0];
          sdat_d  = {64'd0, store_data[255:64]};
          we_d    = 1'b1;
        end
      end
      LD_ISSUE: begin
        if (cnt_q == 2'd0) begin
          cnt_d       = 2'd1;
          addr_d      = addr_q + 32'(LOAD_BEAT_BYTES);
          issue_d     = 1'b1;
          issue_tag_d = 1'b1;
        end else begin
          state_d = (cap_vld && cap_tag) ? DONE : LD_DRAIN;
        end
      end
      LD_DRAIN: if (cap_vld && cap_tag) state_d = DONE;
      ST_WRITE: begin
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end else begin
          cnt_d  = cnt_q + 2'd1;
          addr_d = addr_q + 32'(STORE_BEAT_BYTES);
          wdat_d = sdat_q[63:0];
          sdat_d = {64'd0, sdat_q[255:64]};
          we_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wdat_q  <= 64'd0;
      we_q    <= 1'b0;
      ld_q    <= 256'd0;
      tvld_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      we_q      <= we_d;
      ld_q      <= ld_d;
      tvld_q[0] <= issue_d;
      for (int i = 1; i < READ_LATENCY; i++) tvld_q[i] <= tvld_q[i-1];
    end
  end

  // Payload registers: qualified by state/tvld, so they need no reset.
  always_ff @(posedge clk) begin
    sdat_q    <= sdat_d;
    ttag_q[0] <= issue_tag_d;
    for (int i = 1; i < READ_LATENCY; i++) ttag_q[i] <= ttag_q[i-1];
  end

  assign mem_address      = addr_q;
  assign mem_vector_input = wdat_q;
  assign mem_write_enable = we_q;
  assign load_data        = ld_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign stall            = ((state_q == IDLE) && (start_load || start_store)) ||
                            ((state_q != IDLE) && (state_q != DONE));

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Bench for vector_mem_sequencer: READ_LATENCY=1 and =3 instances share stimulus and
// are checked each cycle against a transaction-level schedule model plus literal expectations.
module tb_vector_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1, start_load = 1'b0, start_store = 1'b0;
  logic [31:0]  base_address = 32'd0;
  logic [255:0] store_data = 256'd0;
  logic [127:0] vo1, vo3;
  logic [31:0]  ma1, ma3;
  logic [63:0]  mv1, mv3;
  logic         we1, we3, busy1, busy3, done1, done3, stall1, stall3;
  logic [255:0] ld1, ld3;
  logic [31:0]  h0 = 32'd0, h1 = 32'd0;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  vector_mem_sequencer #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start_load(start_load), .start_store(start_store),
    .base_address(base_address), .store_data(store_data), .vector_output(vo1),
    .mem_address(ma1), .mem_vector_input(mv1), .mem_write_enable(we1),
    .load_data(ld1), .busy(busy1), .done(done1), .stall(stall1));

  vector_mem_sequencer #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start_load(start_load), .start_store(start_store),
    .base_address(base_address), .store_data(store_data), .vector_output(vo3),
    .mem_address(ma3), .mem_vector_input(mv3), .mem_write_enable(we3),
    .load_data(ld3), .busy(busy3), .done(done3), .stall(stall3));

  function automatic logic [127:0] memword(input logic [31:0] a);
    if (a == 32'h100) return {32{4'hA}};
    if (a == 32'h110) return {32{4'hB}};
    return {a, ~a, a ^ 32'h1357_9BDF, 32'hC0DE_0000 + a};
  endfunction

  // Memory stage: data for the address presented READ_LATENCY-1 cycles earlier.
  assign vo1 = memword(ma1);
  always @(posedge clk) begin
    h0 <= ma3;
    h1 <= h0;
  end
  assign vo3 = memword(h1);

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: kind 0 idle, 1 load, 2 store; rel = cycles since acceptance.
  int           m_kind[2] = '{0, 0};
  int           m_rel[2]  = '{0, 0};
  logic [31:0]  m_a[2];
  logic [255:0] m_sd[2];
  logic [31:0]  m_addr[2] = '{32'd0, 32'd0};
  logic [63:0]  m_wd[2]   = '{64'd0, 64'd0};
  logic [255:0] m_ld[2]   = '{256'd0, 256'd0};
  logic [31:0]  e_addr[2];
  logic [63:0]  e_wd[2];
  logic [255:0] e_ld[2];
  logic         e_we[2], e_busy[2], e_done[2], e_stall[2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic model_expect(input int d);
    int r;
    r = m_rel[d];
    e_addr[d]  = m_addr[d];
    e_wd[d]    = m_wd[d];
    e_ld[d]    = m_ld[d];
    e_we[d]    = 1'b0;
    e_done[d]  = 1'b0;
    e_busy[d]  = (m_kind[d] != 0);
    e_stall[d] = (m_kind[d] == 0) ? (start_load | start_store) : 1'b1;
    if (m_kind[d] == 1) begin
      if (r == 1) e_addr[d] = m_a[d];
      if (r >= 2) e_addr[d] = m_a[d] + 32'd16;
      if (r == lat(d) + 1) e_ld[d][127:0] = memword(m_a[d]);
      if (r == lat(d) + 2) begin
        e_ld[d][255:128] = memword(m_a[d] + 32'd16);
        e_done[d]  = 1'b1;
        e_stall[d] = 1'b0;
      end
    end else if (m_kind[d] == 2) begin
      if (r <= 4) begin
        e_addr[d] = m_a[d] + 32'(8 * (r - 1));
        e_wd[d]   = m_sd[d][64*(r-1) +: 64];
        e_we[d]   = 1'b1;
      end else begin
        e_done[d]  = 1'b1;
        e_stall[d] = 1'b0;
      end
    end
    m_addr[d] = e_addr[d];
    m_wd[d]   = e_wd[d];
    m_ld[d]   = e_ld[d];
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_kind[d] = 0; m_rel[d] = 0;
        m_addr[d] = 32'd0; m_wd[d] = 64'd0; m_ld[d] = 256'd0;
      end else if (m_kind[d] == 0) begin
        if (start_load || start_store) begin
          m_kind[d] = start_load ? 1 : 2;
          m_rel[d]  = 1;
          m_a[d]    = {base_address[31:4], 4'h0};
          m_sd[d]   = store_data;
        end
      end else if (m_rel[d] == ((m_kind[d] == 1) ? lat(d) + 2 : 5)) begin
        m_kind[d] = 0; m_rel[d] = 0;
      end else begin
        m_rel[d]++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      model_expect(0);
      model_expect(1);
      chk("l1_addr", ma1, e_addr[0]);   chk("l3_addr", ma3, e_addr[1]);
      chk("l1_wdata", mv1, e_wd[0]);    chk("l3_wdata", mv3, e_wd[1]);
      chk("l1_we", we1, e_we[0]);       chk("l3_we", we3, e_we[1]);
      chk("l1_ldata", ld1, e_ld[0]);    chk("l3_ldata", ld3, e_ld[1]);
      chk("l1_busy", busy1, e_busy[0]); chk("l3_busy", busy3, e_busy[1]);
      chk("l1_done", done1, e_done[0]); chk("l3_done", done3, e_done[1]);
      chk("l1_stall", stall1, e_stall[0]); chk("l3_stall", stall3, e_stall[1]);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    nxt();
    while ((busy1 || busy3) && n < 20) begin
      nxt();
      n++;
    end
    checks++;
    if (busy1 || busy3) begin
      errors++;
      $display("FAIL settle_timeout: busy1=%0b busy3=%0b required 0", busy1, busy3);
    end
    nxt();
  endtask

  logic any_we;

  initial begin
    @(posedge clk); #1;
    cmp_en = 1'b1;
    nxt();
    reset = 1'b0;
    repeat (3) nxt();
    @(negedge clk);
    chk("idle_addr", ma1, 0); chk("idle_ldata", ld1, 0);
    chk("idle_stall", stall1, 0); chk("idle_busy", busy3, 0);

    // Load at 0x104 (aligned 0x100)
    nxt();
    start_load = 1'b1; base_address = 32'h104;
    @(negedge clk); chk("ld_stall_c0", stall1, 1);
    nxt(); start_load = 1'b0;
    @(negedge clk); chk("ld_addr_c1", ma1, 32'h100); chk("ld_stall_c1", stall1, 1);
    nxt();
    @(negedge clk); chk("ld_addr_c2", ma1, 32'h110); chk("ld_done_c2", done1, 0);
    nxt();
    @(negedge clk); chk("ld_done_c3", done1, 1); chk("ld_stall_c3", stall1, 0);
    chk("ld_data", ld1, {{32{4'hB}}, {32{4'hA}}});
    settle();

    // Store at 0x200
    store_data = {64'h4, 64'h3, 64'h2, 64'h1}; base_address = 32'h200; start_store = 1'b1;
    nxt(); start_store = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("st_addr", ma1, 32'h200 + 8 * k); chk("st_data", mv1, k + 1); chk("st_we", we1, 1);
      nxt();
    end
    @(negedge clk); chk("st_done_c5", done1, 1); chk("st_we_c5", we1, 0);
    settle();

    // Simultaneous load/store, then a store pulse mid-load: only the load runs
    any_we = 1'b0;
    base_address = 32'h300; store_data = {4{64'hDEAD_BEEF_0000_0001}};
    start_load = 1'b1; start_store = 1'b1;
    nxt(); start_load = 1'b0; start_store = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) start_store = 1'b1;
      if (k == 2) start_store = 1'b0;
      @(negedge clk); any_we = any_we | we1 | we3;
      nxt();
    end
    chk("both_no_we", any_we, 0);
    chk("both_ld_lo", ld3[127:0], memword(32'h300));
    settle();

    // Wrapping load at 0xFFFFFFF0, checked on the READ_LATENCY=3 instance
    base_address = 32'hFFFF_FFF0; start_load = 1'b1;
    nxt(); start_load = 1'b0;
    @(negedge clk); chk("wrap_addr_c1", ma3, 32'hFFFF_FFF0);
    nxt();
    @(negedge clk); chk("wrap_addr_c2", ma3, 32'h0);
    nxt(); nxt();
    @(negedge clk); chk("wrap_done_c4", done3, 0);
    nxt();
    @(negedge clk); chk("wrap_done_c5", done3, 1);
    settle();

    // Reset during store beat 2, then a normal load
    store_data = {64'h44, 64'h33, 64'h22, 64'h11}; base_address = 32'h400; start_store = 1'b1;
    nxt(); start_store = 1'b0;
    nxt(); nxt();
    @(negedge clk); chk("rst_beat2_addr", ma1, 32'h410); chk("rst_beat2_we", we1, 1);
    reset = 1'b1;
    nxt(); reset = 1'b0;
    @(negedge clk); chk("rst_we", we1, 0); chk("rst_busy", busy1, 0); chk("rst_ldata", ld1, 0);
    nxt();
    base_address = 32'h100; start_load = 1'b1;
    nxt(); start_load = 1'b0;
    nxt(); nxt();
    @(negedge clk); chk("post_rst_done", done1, 1);
    chk("post_rst_data", ld1, {{32{4'hB}}, {32{4'hA}}});
    settle();

    // Reset while READ_LATENCY=3 beats are in flight: late data is discarded
    base_address = 32'h500; start_load = 1'b1;
    nxt(); start_load = 1'b0;
    nxt();
    reset = 1'b1;
    nxt(); reset = 1'b0;
    repeat (4) nxt();
    @(negedge clk); chk("flight_ldata", ld3, 0); chk("flight_busy", busy3, 0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
